// File: rtl/display_scheduler.sv
// Time-shares the seven-segment display between timer, WPM and accuracy, converting the
// selected source to BCD with a serial double-dabble. Optional DISP_BLANK_LZ_EN blanks leading zeros.
module display_scheduler #(
   parameter int REFRESH_CYCLES = 1_000_000,
   parameter int PAGE_CYCLES    = 200_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        test_active,
   input  logic [16:0] timer_val,
   input  logic [16:0] wpm_val,
   input  logic [16:0] acc_val,
   output logic [11:0] wpm_integer,
   output logic [7:0]  wpm_decimal,
   output logic [1:0]  page,
   output logic        busy,
   output logic        update
);
   localparam int RW = $clog2(REFRESH_CYCLES + 1);
   localparam int PW = $clog2(PAGE_CYCLES + 1);
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
   localparam logic [PW-1:0] PAGE_LAST    = PW'(PAGE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

   state_t         state_reg, state_next;
   logic           pending_reg, pending_next;
   logic           consume;
   logic           test_prev_reg;
   logic [1:0]     page_next;
   logic [PW-1:0]  page_cnt_reg, page_cnt_next;
   logic [RW-1:0]  refresh_cnt_reg;
   logic           tick;
   logic [16:0]    bin_sr_reg;
   logic [19:0]    bcd_reg, bcd_adj;
   logic [4:0]     iter_reg;
   logic [16:0]    src_sel, src_sat;
   logic [11:0]    int_digits;

   assign tick = (refresh_cnt_reg == REFRESH_LAST);
   assign busy = (state_reg != IDLE);

   always_comb begin
      page_next     = page;
      page_cnt_next = page_cnt_reg + PW'(1);
      if (test_active) begin
         page_next     = 2'd0;
         page_cnt_next = '0;
      end else if (test_prev_reg) begin
         page_next     = 2'd1;
         page_cnt_next = '0;
      end else if (page_cnt_reg == PAGE_LAST) begin
         page_cnt_next = '0;
         page_next     = (page == 2'd1) ? 2'd2 : 2'd1;
      end
   end

   always_comb begin
      state_next = state_reg;
      consume    = 1'b0;
      case (state_reg)
         IDLE:   if (pending_reg) begin
                    state_next = LOAD;
                    consume    = 1'b1;
                 end
         LOAD:   state_next = SHIFT;
         SHIFT:  if (iter_reg == 5'd1) state_next = COMMIT;
         COMMIT: if (pending_reg) begin
                    state_next = LOAD;
                    consume    = 1'b1;
                 end else begin
                    state_next = IDLE;
                 end
         default: state_next = IDLE;
      endcase
      // A new event in the same cycle as a consume must survive, so set beats clear.
      pending_next = (pending_reg & ~consume) | tick | (page_next != page);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         pending_reg     <= 1'b1;
         test_prev_reg   <= 1'b0;
         page            <= 2'd1;
         page_cnt_reg    <= '0;
         refresh_cnt_reg <= '0;
      end else begin
         state_reg       <= state_next;
         pending_reg     <= pending_next;
         test_prev_reg   <= test_active;
         page            <= page_next;
         page_cnt_reg    <= page_cnt_next;
         refresh_cnt_reg <= tick ? '0 : refresh_cnt_reg + RW'(1);
      end
   end

   always_comb begin
      case (page)
         2'd0:    src_sel = timer_val;
         2'd1:    src_sel = wpm_val;
         default: src_sel = acc_val;
      endcase
      src_sat = (src_sel > 17'd99999) ? 17'd99999 : src_sel;
   end

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_dabble
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
      end
   endgenerate

   always_comb begin
      int_digits = bcd_reg[19:8];
`ifdef DISP_BLANK_LZ_EN
      if (bcd_reg[19:16] == 4'd0) int_digits[11:8] = 4'hF;
      if (bcd_reg[19:12] == 8'd0) int_digits[7:4]  = 4'hF;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_sr_reg  <= '0;
         bcd_reg     <= '0;
         iter_reg    <= '0;
         wpm_integer <= 12'h000;
         wpm_decimal <= 8'h00;
         update      <= 1'b0;
      end else begin
         update <= 1'b0;
         case (state_reg)
            LOAD: begin
               bin_sr_reg <= src_sat;
               bcd_reg    <= '0;
               iter_reg   <= 5'd17;
            end
            SHIFT: begin
               {bcd_reg, bin_sr_reg} <= {bcd_adj, bin_sr_reg} << 1;
               iter_reg              <= iter_reg - 5'd1;
            end
            COMMIT: begin
               wpm_integer <= int_digits;
               wpm_decimal <= bcd_reg[7:0];
               update      <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: reset, latency, saturation, test mode, snapshot,
// coalescing and asynchronous mid-conversion reset. Honours DISP_BLANK_LZ_EN for expectations.
module tb_display_scheduler;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        test_active;
   logic [16:0] timer_val, wpm_val, acc_val;
   logic [11:0] wpm_integer;
   logic [7:0]  wpm_decimal;
   logic [1:0]  page;
   logic        busy, update;

   int checks = 0;
   int errors = 0;

`ifdef DISP_BLANK_LZ_EN
   localparam logic [11:0] EXP_065 = 12'hF65;
   localparam logic [11:0] EXP_030 = 12'hF30;
   localparam logic [11:0] EXP_012 = 12'hF12;
`else
   localparam logic [11:0] EXP_065 = 12'h065;
   localparam logic [11:0] EXP_030 = 12'h030;
   localparam logic [11:0] EXP_012 = 12'h012;
`endif

   display_scheduler #(.REFRESH_CYCLES(50), .PAGE_CYCLES(400)) dut (
      .clk(clk), .rst_n(rst_n), .test_active(test_active),
      .timer_val(timer_val), .wpm_val(wpm_val), .acc_val(acc_val),
      .wpm_integer(wpm_integer), .wpm_decimal(wpm_decimal),
      .page(page), .busy(busy), .update(update)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_update(input string tag, input int bound, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!update && cyc < bound);
      check(tag, update, 1);
   endtask

   initial begin
      int cyc, n, first_at, second_at;
      logic [11:0] first_int, second_int;
      logic [7:0]  first_dec, second_dec;

      rst_n = 1'b0; test_active = 1'b0;
      timer_val = 17'd0; wpm_val = 17'd6543; acc_val = 17'd120000;
      repeat (3) @(negedge clk);
      check("rst_int", wpm_integer, 12'h000);
      check("rst_dec", wpm_decimal, 8'h00);
      check("rst_page", page, 2'd1);
      check("rst_busy", busy, 1'b0);
      check("rst_update", update, 1'b0);

      rst_n = 1'b1;
      @(negedge clk);
      check("busy_after_release", busy, 1'b1);
      n = 0;
      repeat (18) begin
         @(negedge clk);
         if (update) n++;
      end
      check("no_early_update", n, 0);
      check("no_partial_int", wpm_integer, 12'h000);
      @(negedge clk);
      check("first_update", update, 1'b1);
      check("first_int", wpm_integer, EXP_065);
      check("first_dec", wpm_decimal, 8'h43);
      $display("txn reset-release: int=%h dec=%h", wpm_integer, wpm_decimal);

      test_active = 1'b1; timer_val = 17'd3000;
      @(negedge clk);
      check("tmode_page", page, 2'd0);
      wait_update("tmode_update", 40, cyc);
      check("tmode_latency", cyc, 20);
      check("tmode_int", wpm_integer, EXP_030);
      check("tmode_dec", wpm_decimal, 8'h00);
      $display("txn test-mode: int=%h dec=%h", wpm_integer, wpm_decimal);

      test_active = 1'b0;
      @(negedge clk);
      check("results_page", page, 2'd1);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (page != 2'd2 && cyc < 500);
      check("page_dwell", cyc, 400);
      wait_update("sat_update", 30, cyc);
      check("sat_int", wpm_integer, 12'h999);
      check("sat_dec", wpm_decimal, 8'h99);
      $display("txn saturation: int=%h dec=%h", wpm_integer, wpm_decimal);

      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (page != 2'd1 && cyc < 500);
      check("page_back_to_wpm", page, 2'd1);
      repeat (6) @(negedge clk);
      check("snap_busy", busy, 1'b1);
      wpm_val = 17'd1200;
      wait_update("snap_update1", 30, cyc);
      check("snap_int_old", wpm_integer, EXP_065);
      check("snap_dec_old", wpm_decimal, 8'h43);
      wait_update("snap_update2", 60, cyc);
      check("snap_gap", cyc, 19);
      check("snap_int_new", wpm_integer, EXP_012);
      check("snap_dec_new", wpm_decimal, 8'h00);
      $display("txn snapshot: int=%h dec=%h", wpm_integer, wpm_decimal);

      // Align to a tick-driven commit: the next tick falls 30 cycles later.
      wait_update("coal_align", 60, cyc);
      repeat (20) @(negedge clk);
      test_active = 1'b1;
      repeat (5) @(negedge clk);
      test_active = 1'b0;
      n = 0; first_at = 0; second_at = 0;
      first_int = '0; second_int = '0; first_dec = '0; second_dec = '0;
      for (int i = 1; i <= 74; i++) begin
         @(negedge clk);
         if (update) begin
            n++;
            if (n == 1) begin
               first_at = i; first_int = wpm_integer; first_dec = wpm_decimal;
            end else if (n == 2) begin
               second_at = i; second_int = wpm_integer; second_dec = wpm_decimal;
            end
         end
      end
      check("coal_count", n, 2);
      check("coal_period", second_at - first_at, 19);
      check("coal_first_int", first_int, EXP_030);
      check("coal_first_dec", first_dec, 8'h00);
      check("coal_second_int", second_int, EXP_012);
      check("coal_second_dec", second_dec, 8'h00);
      $display("txn coalesce: n=%0d first=%h second=%h", n, first_int, second_int);

      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!busy && cyc < 60);
      check("mid_busy", busy, 1'b1);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_int", wpm_integer, 12'h000);
      check("mid_rst_dec", wpm_decimal, 8'h00);
      check("mid_rst_update", update, 1'b0);
      n = 0;
      repeat (5) begin
         @(negedge clk);
         if (update) n++;
      end
      check("mid_rst_no_update", n, 0);
      rst_n = 1'b1;
      wait_update("post_rst_update", 30, cyc);
      check("post_rst_latency", cyc, 20);
      check("post_rst_int", wpm_integer, EXP_012);
      check("post_rst_dec", wpm_decimal, 8'h00);
      $display("txn mid-reset: int=%h dec=%h", wpm_integer, wpm_decimal);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/display_scheduler.md
# display_scheduler

Sequencer that sits in front of the five-digit seven-segment driver and decides what it shows. It time-shares the display between three binary sources: test countdown, WPM, and accuracy. It converts the selected value to BCD with a multi-cycle double-dabble engine and presents stable `wpm_integer`/`wpm_decimal` BCD words, which are updated atomically once per conversion.

## Interface
Parameters:
- `REFRESH_CYCLES`, default 1_000_000: clock cycles between periodic reconversions (10 ms at 100 MHz).
- `PAGE_CYCLES`, default 200_000_000: dwell time per results page (2 s at 100 MHz).

Ports:
- `clk` in 1: system clock; all logic is on its rising edge. One clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `test_active` in 1: 1 while a typing test runs.
- `timer_val` in 17: seconds remaining ×100, unsigned binary.
- `wpm_val` in 17: WPM ×100, unsigned binary.
- `acc_val` in 17: accuracy percent ×100, unsigned binary.
- `wpm_integer` out 12: three BCD digits, integer part; `[11:8]` is hundreds.
- `wpm_decimal` out 8: two BCD digits, fractional part; `[7:4]` is tenths.
- `page` out 2: currently selected source. 0 = timer, 1 = WPM, 2 = accuracy. 3 never occurs.
- `busy` out 1: high while a conversion is in progress.
- `update` out 1: one-cycle pulse in the cycle the new BCD outputs become visible.

## Operation
- **Page selection**
  - While `test_active`=1: `page`=0, and the page counter is held at 0.
  - On the 1→0 edge of `test_active`: `page`=1, page counter cleared.
  - While `test_active`=0: `page` toggles 1↔2 every `PAGE_CYCLES` cycles.
  - Any change of `page` sets the `pending` flag.
- **Refresh counter**
  - Free-running from 0 to `REFRESH_CYCLES`-1.
  - Wrap pulses `tick`, which sets `pending`.
- **FSM: IDLE → LOAD → SHIFT → COMMIT → IDLE**
  - IDLE: when `pending`=1, clear `pending` and go to LOAD.
  - LOAD (1 cycle): snapshot the source selected by `page` into a 17-bit shift register. Values above 99999 saturate to 99999. Clear the 20-bit BCD accumulator. Set the iteration counter to 17.
  - SHIFT (17 cycles): each cycle, add 3 to every accumulator nibble ≥5, then shift {accumulator, shift register} left by 1 bit. Decrement the counter; leave SHIFT when it reaches 0.
  - COMMIT (1 cycle): load accumulator digits [19:8] into `wpm_integer` and [7:0] into `wpm_decimal`, and pulse `update`.
- `busy` is 1 in LOAD, SHIFT and COMMIT.
- A `tick` or page change while `busy` sets `pending`; the running conversion still finishes with its snapshot. `pending` is a single bit, so multiple events coalesce into one reconversion. From COMMIT, if `pending` is set, go directly to LOAD.
- Source value changes after LOAD have no effect until the next conversion.
- Outputs hold their values between commits; they never show partial results.

## Timing
- Reset values: `wpm_integer`=12'h000, `wpm_decimal`=8'h00, `page`=1, `busy`=0, `update`=0. FSM in IDLE, `pending`=1 so a conversion starts on the first cycle after reset release. All counters are 0.
- Latency: `pending` seen in IDLE at cycle N → LOAD at N+1, SHIFT at N+2..N+18, COMMIT at N+19. Outputs and `update` are valid from N+20 (registered).
- Back-to-back conversions: COMMIT → LOAD, giving a period of 19 cycles.
- Reset asserted mid-operation: all state returns to reset values immediately, with no commit of partial data.
- `test_active` is synchronous to `clk`; synchronizing it is the caller's job.

## Configuration
- `DISP_BLANK_LZ_EN` defined: leading-zero blanking.
  - At COMMIT, the hundreds digit is replaced with 4'hF if it is 0.
  - The tens digit is replaced with 4'hF if both hundreds and tens are 0.
  - The driver renders 4'hF as blank. The units digit and decimal digits are never blanked.
- Undefined: zeros are output as 4'h0 unchanged.

## Test plan
Bench uses `REFRESH_CYCLES`=50 and `PAGE_CYCLES`=400.
- **Reset:** hold `rst_n`=0 → outputs 0, `page`=1, `busy`=0. Release with `wpm_val`=6543 → `update` pulse 20 cycles later, with `wpm_integer`=12'h065 and `wpm_decimal`=8'h43.
- **Saturation:** `acc_val`=120000, wait for `page`=2 → `wpm_integer`=12'h999, `wpm_decimal`=8'h99.
- **Test mode:** `test_active`=1, `timer_val`=3000 → `page`=0 next cycle, then 12'h030/8'h00. With `DISP_BLANK_LZ_EN` defined: 12'hF30/8'h00.
- **Snapshot:** `wpm_val` changes 6543→1200 at SHIFT cycle 5 → that commit shows 065/43, and the next tick's commit shows 012/00.
- **Coalescing:** page change plus `tick` both during SHIFT → exactly two `update` pulses, 19 cycles apart, and the second reflects the new page.
- **Mid-operation reset:** `rst_n` low during SHIFT → `busy`=0 and outputs 0 asynchronously, with no `update` pulse.
